// File: rtl/rhythm_pkg.sv
// Shared types and constants for the rhythm sequencer.
// Holds the sequencer state enum, default sizing, and the LFSR seed/taps.
package rhythm_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam int DEF_LANES        = 4;
    localparam int DEF_PAT_DEPTH    = 16;
    localparam int DEF_NUM_LEVELS   = 4;
    localparam int DEF_ADDR_W       = 18;
    localparam int DEF_AUDIO_LENGTH = 176400;
    localparam int DEF_BEAT_SAMPLES = 22050;
    localparam int DEF_BEATS_PER_MEASURE = 8;

    // Fibonacci LFSR, taps 16,14,13,11 (bits 15,13,12,10)
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/rhythm_pattern_ram.sv
// Per-level note pattern storage plus per-level pattern length registers.
// Ports: clk_i/rst_ni; we_i/len_we_i write strobes with wr_level_i, wr_addr_i,
// wr_data_i; rd_level_i/rd_addr_i select rd_data_o (combinational read);
// rd_last_o is the last valid index (length-1) of rd_level_i.
module rhythm_pattern_ram
    import rhythm_pkg::*;
#(
    parameter int LANES      = DEF_LANES,
    parameter int PAT_DEPTH  = DEF_PAT_DEPTH,
    parameter int NUM_LEVELS = DEF_NUM_LEVELS
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          we_i,
    input  logic                          len_we_i,
    input  logic [$clog2(NUM_LEVELS)-1:0] wr_level_i,
    input  logic [$clog2(PAT_DEPTH)-1:0]  wr_addr_i,
    input  logic [LANES-1:0]              wr_data_i,
    input  logic [$clog2(NUM_LEVELS)-1:0] rd_level_i,
    input  logic [$clog2(PAT_DEPTH)-1:0]  rd_addr_i,
    output logic [LANES-1:0]              rd_data_o,
    output logic [$clog2(PAT_DEPTH)-1:0]  rd_last_o
);

    localparam int IDX_W = $clog2(PAT_DEPTH);

    logic [LANES-1:0] mem_q [NUM_LEVELS][PAT_DEPTH];
    logic [IDX_W-1:0] last_q [NUM_LEVELS];

    // Table contents are intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wr_level_i][wr_addr_i] <= wr_data_i;
        end
    end

    // Lengths are stored as last index; reset means full depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_LEVELS; i++) begin
                last_q[i] <= IDX_W'(PAT_DEPTH - 1);
            end
        end else if (len_we_i) begin
            last_q[wr_level_i] <= wr_addr_i;
        end
    end

    assign rd_data_o = mem_q[rd_level_i][rd_addr_i];
    assign rd_last_o = last_q[rd_level_i];

endmodule

// File: rtl/rhythm_sequencer.sv
// Rhythm sequencer: audio address, beat/measure pulses and lane note events.
// Inputs: clk, rst_n, sample_tick, game_start, pause, abort, difficulty,
// pattern writes (pat_we, pat_len_we, pat_level, pat_addr, pat_data),
// note_ready. Outputs: game_active, paused, audio_addr, beat_pulse,
// measure_pulse, note_valid, new_note, note_overflow, game_done.
// RHYTHM_LFSR_EN: top level draws notes from a 16-bit LFSR, not the table.
module rhythm_sequencer
    import rhythm_pkg::*;
#(
    parameter int LANES             = DEF_LANES,
    parameter int PAT_DEPTH         = DEF_PAT_DEPTH,
    parameter int NUM_LEVELS        = DEF_NUM_LEVELS,
    parameter int ADDR_W            = DEF_ADDR_W,
    parameter int AUDIO_LENGTH      = DEF_AUDIO_LENGTH,
    parameter int BEAT_SAMPLES      = DEF_BEAT_SAMPLES,
    parameter int BEATS_PER_MEASURE = DEF_BEATS_PER_MEASURE
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          sample_tick,
    input  logic                          game_start,
    input  logic                          pause,
    input  logic                          abort,
    input  logic [$clog2(NUM_LEVELS)-1:0] difficulty,
    input  logic                          pat_we,
    input  logic [$clog2(NUM_LEVELS)-1:0] pat_level,
    input  logic [$clog2(PAT_DEPTH)-1:0]  pat_addr,
    input  logic [LANES-1:0]              pat_data,
    input  logic                          pat_len_we,
    input  logic                          note_ready,
    output logic                          game_active,
    output logic                          paused,
    output logic [ADDR_W-1:0]             audio_addr,
    output logic                          beat_pulse,
    output logic                          measure_pulse,
    output logic                          note_valid,
    output logic [LANES-1:0]              new_note,
    output logic                          note_overflow,
    output logic                          game_done
);

    localparam int LVL_W = $clog2(NUM_LEVELS);
    localparam int IDX_W = $clog2(PAT_DEPTH);
    localparam int BC_W  = (BEAT_SAMPLES > 1) ? $clog2(BEAT_SAMPLES) : 1;
    localparam int BM_W  = (BEATS_PER_MEASURE > 1) ?
                           $clog2(BEATS_PER_MEASURE) : 1;

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(AUDIO_LENGTH - 1);
    localparam logic [BC_W-1:0]   BEAT_LAST = BC_W'(BEAT_SAMPLES - 1);
    localparam logic [BM_W-1:0]   BIM_LAST  = BM_W'(BEATS_PER_MEASURE - 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [BC_W-1:0]   beat_q, beat_d;
    logic [BM_W-1:0]   bim_q, bim_d;
    logic [BC_W-1:0]   ntmr_q, ntmr_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [LVL_W-1:0]  level_q, level_d;
    logic              beat_pls_q, beat_pls_d;
    logic              meas_pls_q, meas_pls_d;
    logic              valid_q, valid_d;
    logic [LANES-1:0]  note_q, note_d;
    logic              ovf_q, ovf_d;
`ifdef RHYTHM_LFSR_EN
    logic [15:0]       lfsr_q, lfsr_d;
`endif

    logic              step;
    logic              ev;
    logic [LANES-1:0]  ev_mask;
    logic [31:0]       ivl;
    logic [BC_W-1:0]   note_last;
    logic [LANES-1:0]  pat_rd;
    logic [IDX_W-1:0]  pat_last;

    rhythm_pattern_ram #(
        .LANES      (LANES),
        .PAT_DEPTH  (PAT_DEPTH),
        .NUM_LEVELS (NUM_LEVELS)
    ) u_ram (
        .clk_i      (clk),
        .rst_ni     (rst_n),
        .we_i       (pat_we && state_q == ST_IDLE),
        .len_we_i   (pat_len_we && state_q == ST_IDLE),
        .wr_level_i (pat_level),
        .wr_addr_i  (pat_addr),
        .wr_data_i  (pat_data),
        .rd_level_i (level_q),
        .rd_addr_i  (idx_q),
        .rd_data_o  (pat_rd),
        .rd_last_o  (pat_last)
    );

    // Intervals shorter than one tick collapse to a note every tick.
    assign ivl       = 32'(BEAT_SAMPLES) >> level_q;
    assign note_last = (ivl > 32'd1) ? BC_W'(ivl - 32'd1) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            beat_q     <= '0;
            bim_q      <= '0;
            ntmr_q     <= '0;
            idx_q      <= '0;
            level_q    <= '0;
            beat_pls_q <= 1'b0;
            meas_pls_q <= 1'b0;
            valid_q    <= 1'b0;
            note_q     <= '0;
            ovf_q      <= 1'b0;
`ifdef RHYTHM_LFSR_EN
            lfsr_q     <= LFSR_SEED;
`endif
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            beat_q     <= beat_d;
            bim_q      <= bim_d;
            ntmr_q     <= ntmr_d;
            idx_q      <= idx_d;
            level_q    <= level_d;
            beat_pls_q <= beat_pls_d;
            meas_pls_q <= meas_pls_d;
            valid_q    <= valid_d;
            note_q     <= note_d;
            ovf_q      <= ovf_d;
`ifdef RHYTHM_LFSR_EN
            lfsr_q     <= lfsr_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        beat_d     = beat_q;
        bim_d      = bim_q;
        ntmr_d     = ntmr_q;
        idx_d      = idx_q;
        level_d    = level_q;
        beat_pls_d = 1'b0;
        meas_pls_d = 1'b0;
        valid_d    = valid_q;
        note_d     = note_q;
        ovf_d      = 1'b0;
        step       = 1'b0;
        ev         = 1'b0;
        ev_mask    = '0;
`ifdef RHYTHM_LFSR_EN
        lfsr_d     = lfsr_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (game_start) begin
                    state_d = ST_RUN;
                    addr_d  = '0;
                    beat_d  = '0;
                    bim_d   = '0;
                    ntmr_d  = '0;
                    idx_d   = '0;
                    level_d = difficulty;
`ifdef RHYTHM_LFSR_EN
                    lfsr_d  = LFSR_SEED;
`endif
                end
            end
            ST_RUN: begin
                step = sample_tick;
                // The final tick wins over a simultaneous pause.
                if (sample_tick && addr_q == ADDR_LAST) begin
                    state_d = ST_DONE;
                end else if (pause) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (!pause) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort) begin
            state_d = ST_IDLE;
            step    = 1'b0;
        end

        if (step) begin
            if (addr_q != ADDR_LAST) begin
                addr_d = addr_q + ADDR_W'(1);
            end
            if (beat_q == BEAT_LAST) begin
                beat_d     = '0;
                beat_pls_d = 1'b1;
                if (bim_q == BIM_LAST) begin
                    bim_d      = '0;
                    meas_pls_d = 1'b1;
                end else begin
                    bim_d = bim_q + BM_W'(1);
                end
            end else begin
                beat_d = beat_q + BC_W'(1);
            end
            if (ntmr_q == note_last) begin
                ntmr_d  = '0;
                ev      = 1'b1;
                ev_mask = pat_rd;
                idx_d   = (idx_q == pat_last) ? '0 : idx_q + IDX_W'(1);
`ifdef RHYTHM_LFSR_EN
                if (level_q == LVL_W'(NUM_LEVELS - 1)) begin
                    ev_mask = lfsr_q[LANES-1:0];
                    lfsr_d  = lfsr_next(lfsr_q);
                end
`endif
            end else begin
                ntmr_d = ntmr_q + BC_W'(1);
            end
        end

        if (state_d == ST_RUN || state_d == ST_PAUSE) begin
            if (valid_q && note_ready) begin
                valid_d = 1'b0;
            end
            if (ev && ev_mask != '0) begin
                // A held, unaccepted note is kept; the newcomer is dropped.
                if (valid_q && !note_ready) begin
                    ovf_d = 1'b1;
                end else begin
                    valid_d = 1'b1;
                    note_d  = ev_mask;
                end
            end
        end else begin
            valid_d = 1'b0;
            note_d  = '0;
        end
    end

    assign game_active   = (state_q == ST_RUN) || (state_q == ST_PAUSE);
    assign paused        = (state_q == ST_PAUSE);
    assign game_done     = (state_q == ST_DONE);
    assign audio_addr    = addr_q;
    assign beat_pulse    = beat_pls_q;
    assign measure_pulse = meas_pls_q;
    assign note_valid    = valid_q;
    assign new_note      = note_q;
    assign note_overflow = ovf_q;

endmodule

// File: tb/tb_rhythm_sequencer.sv
// Directed bench for rhythm_sequencer with a short song (64 samples,
// 8 samples per beat, 4 beats per measure, 4 lanes).
module tb_rhythm_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       game_start = 1'b0;
    logic       pause = 1'b0;
    logic       abort = 1'b0;
    logic [1:0] difficulty = '0;
    logic       pat_we = 1'b0;
    logic [1:0] pat_level = '0;
    logic [3:0] pat_addr = '0;
    logic [3:0] pat_data = '0;
    logic       pat_len_we = 1'b0;
    logic       note_ready = 1'b0;
    logic       game_active;
    logic       paused;
    logic [7:0] audio_addr;
    logic       beat_pulse;
    logic       measure_pulse;
    logic       note_valid;
    logic [3:0] new_note;
    logic       note_overflow;
    logic       game_done;

    int errors = 0;
    int checks = 0;

    rhythm_sequencer #(
        .LANES             (4),
        .PAT_DEPTH         (16),
        .NUM_LEVELS        (4),
        .ADDR_W            (8),
        .AUDIO_LENGTH      (64),
        .BEAT_SAMPLES      (8),
        .BEATS_PER_MEASURE (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .sample_tick   (sample_tick),
        .game_start    (game_start),
        .pause         (pause),
        .abort         (abort),
        .difficulty    (difficulty),
        .pat_we        (pat_we),
        .pat_level     (pat_level),
        .pat_addr      (pat_addr),
        .pat_data      (pat_data),
        .pat_len_we    (pat_len_we),
        .note_ready    (note_ready),
        .game_active   (game_active),
        .paused        (paused),
        .audio_addr    (audio_addr),
        .beat_pulse    (beat_pulse),
        .measure_pulse (measure_pulse),
        .note_valid    (note_valid),
        .new_note      (new_note),
        .note_overflow (note_overflow),
        .game_done     (game_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       tick;
        logic       ready;
        logic       exp_valid;
        logic [3:0] exp_note;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [14];
    logic [3:0] seq [3];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     nm, act, exp, $time);
        end
    endtask

    task automatic wr_pat(input logic [1:0] l, input logic [3:0] a,
                          input logic [3:0] d);
        pat_level = l;
        pat_addr  = a;
        pat_data  = d;
        pat_we    = 1'b1;
        cyc();
        pat_we    = 1'b0;
    endtask

    task automatic wr_len(input logic [1:0] l, input logic [3:0] last);
        pat_level  = l;
        pat_addr   = last;
        pat_len_we = 1'b1;
        cyc();
        pat_len_we = 1'b0;
    endtask

    task automatic start(input logic [1:0] lvl);
        difficulty = lvl;
        game_start = 1'b1;
        cyc();
        game_start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        cyc();
        abort = 1'b0;
    endtask

`ifdef RHYTHM_LFSR_EN
    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic fb;
        fb = s[15] ^ s[13] ^ s[12] ^ s[10];
        return {s[14:0], fb};
    endfunction
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Backpressure run at level 1, pattern 0001,0010,0100, events
        // every 4 ticks: tick4 loads, tick8 overflows, tick12 + ready
        // loads 0100 (0010 was dropped with the overflow).
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 4'h0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[7]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b1};
        vecs[8]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[9]  = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b1, 4'h1, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 4'h4, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 4'h0, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 4'h0, 1'b0};
        seq[0] = 4'b0001;
        seq[1] = 4'b0010;
        seq[2] = 4'b0100;

        // Reset
        cyc();
        cyc();
        chk("rst_active", game_active, 0);
        chk("rst_paused", paused, 0);
        chk("rst_addr", audio_addr, 0);
        chk("rst_beat", beat_pulse, 0);
        chk("rst_meas", measure_pulse, 0);
        chk("rst_valid", note_valid, 0);
        chk("rst_note", new_note, 0);
        chk("rst_ovf", note_overflow, 0);
        chk("rst_done", game_done, 0);
        rst_n = 1'b1;
        cyc();

        // Table setup
        for (int l = 0; l < 4; l++)
            for (int a = 0; a < 16; a++)
                wr_pat(2'(l), 4'(a), 4'h0);
        wr_pat(2'd0, 4'd2, 4'b1000);
        wr_pat(2'd1, 4'd0, 4'b0001);
        wr_pat(2'd1, 4'd1, 4'b0010);
        wr_pat(2'd1, 4'd2, 4'b0100);
        wr_len(2'd1, 4'd2);

        // Beat / measure / song end
        note_ready = 1'b1;
        start(2'd0);
        chk("start_active", game_active, 1);
        chk("start_addr", audio_addr, 0);
        sample_tick = 1'b1;
        for (int t = 1; t <= 64; t++) begin
            cyc();
            chk($sformatf("beat_t%0d", t), beat_pulse, (t % 8) == 0);
            chk($sformatf("meas_t%0d", t), measure_pulse, (t % 32) == 0);
            chk($sformatf("done_t%0d", t), game_done, t == 64);
            chk($sformatf("addr_t%0d", t), audio_addr, (t < 64) ? t : 63);
            chk($sformatf("act_t%0d", t), game_active, t < 64);
        end
        sample_tick = 1'b0;
        cyc();
        chk("done_after", game_done, 0);
        chk("idle_after", game_active, 0);

        // Pattern playback, level 1
        start(2'd1);
        sample_tick = 1'b1;
        for (int t = 1; t <= 16; t++) begin
            cyc();
            chk($sformatf("pb_valid_t%0d", t), note_valid, (t % 4) == 0);
            if ((t % 4) == 0)
                chk($sformatf("pb_note_t%0d", t), new_note,
                    seq[((t / 4) - 1) % 3]);
        end
        sample_tick = 1'b0;
        do_abort();

        // Backpressure table
        start(2'd1);
        for (int i = 0; i < 14; i++) begin
            sample_tick = vecs[i].tick;
            note_ready  = vecs[i].ready;
            cyc();
            chk($sformatf("bp_valid_%0d", i), note_valid, vecs[i].exp_valid);
            chk($sformatf("bp_ovf_%0d", i), note_overflow, vecs[i].exp_ovf);
            if (vecs[i].exp_valid)
                chk($sformatf("bp_note_%0d", i), new_note, vecs[i].exp_note);
        end
        sample_tick = 1'b0;
        note_ready  = 1'b0;
        do_abort();

        // Pause
        start(2'd0);
        sample_tick = 1'b1;
        repeat (5) cyc();
        chk("pre_pause_addr", audio_addr, 5);
        pause = 1'b1;
        cyc();
        chk("pause_entry", paused, 1);
        chk("pause_tick_taken", audio_addr, 6);
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk($sformatf("pause_addr_%0d", i), audio_addr, 6);
            chk($sformatf("pause_beat_%0d", i),
                {beat_pulse, measure_pulse}, 2'b00);
        end
        pause = 1'b0;
        sample_tick = 1'b0;
        cyc();
        chk("resume_paused", paused, 0);
        chk("resume_addr", audio_addr, 6);
        sample_tick = 1'b1;
        cyc();
        chk("resume_addr7", audio_addr, 7);
        cyc();
        chk("resume_addr8", audio_addr, 8);
        chk("resume_beat", beat_pulse, 1);

        // Abort at address 30, with a run-time table write attempt
        for (int i = 0; i < 40 && audio_addr != 8'd30; i++) cyc();
        sample_tick = 1'b0;
        chk("abort_addr", audio_addr, 30);
        chk("held_valid", note_valid, 1);
        chk("held_note", new_note, 4'b1000);
        wr_pat(2'd1, 4'd0, 4'b1111);
        wr_len(2'd1, 4'd0);
        do_abort();
        chk("abort_active", game_active, 0);
        chk("abort_done", game_done, 0);
        chk("abort_valid", note_valid, 0);
        cyc();
        chk("abort_done2", game_done, 0);

        note_ready = 1'b1;
        start(2'd1);
        sample_tick = 1'b1;
        for (int t = 1; t <= 8; t++) begin
            cyc();
            if (t == 4) begin
                chk("tbl_valid1", note_valid, 1);
                chk("tbl_note1", new_note, 4'b0001);
            end
            if (t == 8) begin
                chk("tbl_valid2", note_valid, 1);
                chk("tbl_note2", new_note, 4'b0010);
            end
        end
        sample_tick = 1'b0;
        do_abort();

`ifdef RHYTHM_LFSR_EN
        begin
            logic [15:0] lf;
            lf = 16'hACE1;
            note_ready = 1'b1;
            start(2'd3);
            for (int k = 0; k < 12; k++) begin
                sample_tick = 1'b1;
                cyc();
                sample_tick = 1'b0;
                chk($sformatf("lfsr_valid_%0d", k), note_valid,
                    lf[3:0] != 4'h0);
                if (lf[3:0] != 4'h0)
                    chk($sformatf("lfsr_note_%0d", k), new_note, lf[3:0]);
                lf = ref_lfsr(lf);
                cyc();
            end
            do_abort();
        end
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
